// File: rtl/subckt_seq_pkg.sv
// subckt_seq_pkg: shared types and constants for the subcircuit self-test
// sequencer family.
//   seq_state_e  - sequencer FSM states
//   DEF_*        - default LFSR taps, LFSR seed and MISR polynomial
//   cnt_width()  - width of the shared phase counter
package subckt_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    APPLY,
    FLUSH,
    COMPARE,
    DONE
  } seq_state_e;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;
  localparam logic [15:0] DEF_MISR_POLY = 16'h8016;

  // One counter serves every timed phase, so size it for the longest one.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/subckt_test_sequencer_misr.sv
// seq_misr: multiple-input signature register with enable and synchronous clear.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (signature -> 0)
//   clr    in  synchronous clear (wins over en)
//   en     in  compact din this cycle
//   din    in  IN_W response bits, folded into the low signature bits
//   sig    out current signature
module seq_misr
  import subckt_seq_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned IN_W = 1,
  parameter logic [W-1:0] POLY = W'(DEF_MISR_POLY)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [IN_W-1:0] din,
  output logic [W-1:0]    sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
    end
  end

endmodule

// File: rtl/subckt_test_sequencer.sv
// subckt_test_sequencer: self-test controller for one small registered
// subcircuit. Resets it, drives LFSR patterns, compacts its response into a
// MISR and compares the signature with a golden value.
//   ctl_clk     in   clock (also clocks the subcircuit)
//   ctl_rst     in   asynchronous active-low reset
//   start       in   run request, accepted only in IDLE
//   golden_sig  in   expected signature, sampled in COMPARE
//   dut_resp    in   subcircuit output
//   abort       in   (only with SUBCKT_SEQ_ABORT_EN) cancel a run in progress
//   dut_stim    out  subcircuit inputs
//   dut_rst     out  subcircuit active-low reset
//   busy        out  high outside IDLE
//   done        out  one-cycle end-of-run pulse
//   pass/fail   out  sticky verdict, cleared when a new run is accepted
//   signature   out  current MISR value
// Build option: define SUBCKT_SEQ_ABORT_EN to add the abort input.
module subckt_test_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned LFSR_W  = 16,
  parameter int unsigned NUM_PAT = 256,
  parameter int unsigned DUT_LAT = 2,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned MISR_W  = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic              ctl_clk,
  input  logic              ctl_rst,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic              dut_resp,
`ifdef SUBCKT_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [N_IN-1:0]   dut_stim,
  output logic              dut_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [MISR_W-1:0] signature
);

  localparam int unsigned CW = cnt_width(NUM_PAT, RST_CYC, DUT_LAT);
  // An all-zero seed would lock the LFSR.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [DUT_LAT-1:0] vpipe_q;
  logic              abort_take;
  logic              start_take;
  logic              cap_en;

`ifdef SUBCKT_SEQ_ABORT_EN
  assign abort_take = abort && (state_q != IDLE);
  assign start_take = start && !abort && (state_q == IDLE);
`else
  assign abort_take = 1'b0;
  assign start_take = start && (state_q == IDLE);
`endif

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    dut_stim = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_take) state_d = RST_DUT;
      end
      RST_DUT: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      APPLY: begin
        dut_stim = lfsr_q[N_IN-1:0];
        if (cnt_q == CW'(NUM_PAT - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(DUT_LAT - 1)) begin
          state_d = COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPARE: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_take) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // dut_rst is registered so it reads 0 while ctl_rst is asserted, even
  // though IDLE itself releases the subcircuit.
  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      dut_rst <= 1'b0;
      lfsr_q  <= SEED_EFF;
      vpipe_q <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      dut_rst <= (state_d != RST_DUT) && !abort_take;
      // Valid bit enters with each applied pattern and exits DUT_LAT cycles later.
      vpipe_q <= abort_take ? '0 : DUT_LAT'({vpipe_q, (state_q == APPLY)});
      if (start_take) begin
        lfsr_q <= SEED_EFF;
      end else if (state_q == APPLY) begin
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      end
      if (start_take || abort_take) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end else if (state_q == COMPARE) begin
        pass <= (signature == golden_sig);
        fail <= (signature != golden_sig);
      end
    end
  end

  assign cap_en = vpipe_q[DUT_LAT-1] && !abort_take;

  seq_misr #(
    .W    (MISR_W),
    .IN_W (1),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (ctl_clk),
    .rst_n (ctl_rst),
    .clr   (start_take),
    .en    (cap_en),
    .din   (dut_resp),
    .sig   (signature)
  );

endmodule

// File: tb/tb_subckt_test_sequencer.sv
module tb_subckt_test_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] POLY = 16'h8016;
  localparam int NP0  = 8;
  localparam int LAT0 = 2;
  localparam int RC   = 2;
  localparam int CYC0 = RC + NP0 + LAT0 + 2;  // 14
  localparam int CYC1 = RC + 1 + 1 + 2;       // 6

  logic ctl_clk = 1'b0;
  logic ctl_rst = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  logic        start0, start1, abort0, abort1;
  logic [15:0] golden0, golden1, sig0, sig1;
  logic [3:0]  stim0, stim1;
  logic        resp0, resp1, dut_rst0, dut_rst1;
  logic        busy0, busy1, done0, done1, pass0, pass1, fail0, fail1;
  logic        troj0 = 1'b0, troj1 = 1'b0;
  logic        sa, sb;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  subckt_test_sequencer #(.NUM_PAT(NP0), .DUT_LAT(LAT0), .RST_CYC(RC)) u_dut0 (
    .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .start(start0), .golden_sig(golden0),
    .dut_resp(resp0),
`ifdef SUBCKT_SEQ_ABORT_EN
    .abort(abort0),
`endif
    .dut_stim(stim0), .dut_rst(dut_rst0), .busy(busy0), .done(done0),
    .pass(pass0), .fail(fail0), .signature(sig0)
  );

  subckt_test_sequencer #(.NUM_PAT(1), .DUT_LAT(1), .RST_CYC(RC)) u_dut1 (
    .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .start(start1), .golden_sig(golden1),
    .dut_resp(resp1),
`ifdef SUBCKT_SEQ_ABORT_EN
    .abort(abort1),
`endif
    .dut_stim(stim1), .dut_rst(dut_rst1), .busy(busy1), .done(done1),
    .pass(pass1), .fail(fail1), .signature(sig1)
  );

  // Two-stage subcircuit; troj0 inverts the output gate.
  always_ff @(posedge ctl_clk or negedge dut_rst0) begin
    if (!dut_rst0) begin
      sa <= 1'b0; sb <= 1'b0; resp0 <= 1'b0;
    end else begin
      sa <= stim0[0] & stim0[1];
      sb <= stim0[2] ^ stim0[3];
      resp0 <= (sa | sb) ^ troj0;
    end
  end

  // Single-stage version of the same function.
  always_ff @(posedge ctl_clk or negedge dut_rst1) begin
    if (!dut_rst1) resp1 <= 1'b0;
    else           resp1 <= ((stim1[0] & stim1[1]) | (stim1[2] ^ stim1[3])) ^ troj1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 16'h0);
  endfunction

  function automatic logic [3:0] pat_at(input int idx);
    logic [15:0] x;
    x = SEED;
    for (int i = 0; i < idx; i++) x = lfsr_next(x);
    return x[3:0];
  endfunction

  function automatic logic resp_of(input logic [3:0] p, input logic troj);
    return ((p[0] & p[1]) | (p[2] ^ p[3])) ^ troj;
  endfunction

  // Signature after folding the first n responses of the pattern stream.
  function automatic logic [15:0] msig(input int n, input logic troj);
    logic [15:0] x, m;
    x = SEED;
    m = 16'h0;
    for (int i = 0; i < n; i++) begin
      m = (m << 1) ^ (m[15] ? POLY : 16'h0) ^ {15'b0, resp_of(x[3:0], troj)};
      x = lfsr_next(x);
    end
    return m;
  endfunction

  // Starts a run at the current negedge (cycle 0) and checks every cycle.
  task automatic run0(input logic troj, input logic [15:0] golden, input int sp1,
                      input int sp2, input int rst_at, input int abort_at);
    logic [15:0] es, fz;
    logic [3:0]  exp_stim;
    int          ncap;
    es = msig(NP0, troj);
    troj0 = troj;
    golden0 = golden;
    start0 = 1'b1;
    for (int k = 1; k <= CYC0; k++) begin
      @(negedge ctl_clk);
      start0 = 1'b0;
      if (abort_at != 0 && k == abort_at + 1) begin
        abort0 = 1'b0;
        ncap = abort_at - (RC + 1 + LAT0);
        if (ncap < 0) ncap = 0;
        if (ncap > NP0) ncap = NP0;
        fz = msig(ncap, troj);
        chk("abort_busy", busy0, 0);
        chk("abort_dut_rst", dut_rst0, 0);
        chk("abort_done", done0, 0);
        chk("abort_pass", pass0, 0);
        chk("abort_fail", fail0, 0);
        chk("abort_sig", sig0, fz);
        @(negedge ctl_clk);
        chk("abort_dut_rst_rel", dut_rst0, 1);
        chk("abort_idle", busy0, 0);
        chk("abort_sig_frozen", sig0, fz);
        return;
      end
      if (k == rst_at) begin
        ctl_rst = 1'b0;
        #1;
        chk("mrst_dut_rst", dut_rst0, 0);
        chk("mrst_busy", busy0, 0);
        chk("mrst_sig", sig0, 0);
        chk("mrst_stim", stim0, 0);
        chk("mrst_done", done0, 0);
        @(negedge ctl_clk);
        ctl_rst = 1'b1;
        return;
      end
      exp_stim = (k > RC && k <= RC + NP0) ? pat_at(k - RC - 1) : 4'h0;
      chk("busy", busy0, 1);
      chk("done", done0, k == CYC0);
      chk("dut_rst", dut_rst0, k > RC);
      chk("stim", stim0, exp_stim);
      if (k < CYC0) begin
        chk("pass_clr", pass0, 0);
        chk("fail_clr", fail0, 0);
      end else begin
        chk("pass", pass0, golden == es);
        chk("fail", fail0, golden != es);
        chk("signature", sig0, es);
      end
      if (k == sp1 || k == sp2) start0 = 1'b1;
      if (k == abort_at) abort0 = 1'b1;
    end
    @(negedge ctl_clk);
    start0 = 1'b0;
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);
    chk("pass_sticky", pass0, golden == es);
    chk("sig_hold", sig0, es);
  endtask

  task automatic run1(input logic troj);
    logic [15:0] es;
    logic [3:0]  s0;
    s0 = pat_at(0);
    es = msig(1, troj);
    golden1 = ($urandom_range(0, 1) == 1) ? es : ~es;
    troj1 = troj;
    start1 = 1'b1;
    for (int k = 1; k <= CYC1; k++) begin
      @(negedge ctl_clk);
      start1 = 1'b0;
      chk("np1_busy", busy1, 1);
      chk("np1_done", done1, k == CYC1);
      chk("np1_stim", stim1, (k == RC + 1) ? s0 : 4'h0);
      if (k == CYC1) begin
        chk("np1_sig", sig1, es);
        chk("np1_pass", pass1, golden1 == es);
        chk("np1_fail", fail1, golden1 != es);
      end
    end
    @(negedge ctl_clk);
    chk("np1_idle", busy1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] es, g;
    logic        tj;
    int          sp1, sp2;
    start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    golden0 = '0; golden1 = '0;
    repeat (3) @(negedge ctl_clk);
    chk("rst_dut_rst", dut_rst0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_stim", stim0, 0);
    chk("rst_sig", sig0, 0);
    ctl_rst = 1'b1;
    @(negedge ctl_clk);
    chk("idle_dut_rst", dut_rst0, 1);
    chk("idle_busy0", busy0, 0);

    // Golden run with starts at 5 and in DONE, then a trojan run started right after DONE.
    run0(1'b0, msig(NP0, 1'b0), 5, CYC0, 0, 0);
    run0(1'b1, msig(NP0, 1'b0), 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge ctl_clk);
      tj = 1'($urandom_range(0, 1));
      es = msig(NP0, tj);
      g = ($urandom_range(0, 1) == 1) ? es : es ^ 16'($urandom_range(1, 65535));
      sp1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CYC0 - 1)) : 0;
      sp2 = ($urandom_range(0, 1) == 1) ? CYC0 : 0;
      run0(tj, g, sp1, sp2, 0, 0);
    end

    // Mid-run reset, then a clean run.
    run0(1'b0, msig(NP0, 1'b0), 0, 0, 6, 0);
    @(negedge ctl_clk);
    run0(1'b0, msig(NP0, 1'b0), 0, 0, int'($urandom_range(1, CYC0 - 1)), 0);
    @(negedge ctl_clk);
    run0(1'b0, msig(NP0, 1'b0), 0, 0, 0, 0);

`ifdef SUBCKT_SEQ_ABORT_EN
    run0(1'b0, msig(NP0, 1'b0), 0, 0, 0, 7);
    run0(1'b1, msig(NP0, 1'b0), 0, 0, 0, int'($urandom_range(1, CYC0 - 1)));
    run0(1'b0, msig(NP0, 1'b0), 0, 0, 0, 0);
`endif

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge ctl_clk);
      run1(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
